load_size_unit: RTL and testbench

LOAD_SIZE_UNIT -- requirements
Module: load_size_unit

---
 rtl/load_size_unit.sv | 160 ++++++++++++++++
 tb/tb_load_size_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/load_size_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_size_unit
// Description : Sequences one memory read, then extracts, sign- or zero-
//               extends and returns a word/half/byte load result.
// Revision    : 1.0 - initial release
// ============================================================================
module load_size_unit #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  ls_ctrl,
  input  logic [1:0]  addr_lo,
  input  logic        sign_en,
  input  logic [31:0] mem_data,
  output logic        mem_rd,
  output logic [31:0] data_out,
  output logic        done,
  output logic        err,
  output logic        busy
);

  localparam logic [3:0] c_wait_init = 4'(MEM_LAT - 1);
  localparam logic [1:0] c_ls_word   = 2'b00;
  localparam logic [1:0] c_ls_half   = 2'b01;
  localparam logic [1:0] c_ls_byte   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [1:0]  r_ls, w_ls_nxt;
  logic [1:0]  r_addr, w_addr_nxt;
  logic        r_sign, w_sign_nxt;
  logic        r_mem_rd, w_mem_rd_nxt;
  logic        r_done, w_done_nxt;
  logic        r_err, w_err_nxt;
  logic [31:0] r_data_out, w_data_nxt;

  logic        w_legal;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  // Request legality is judged on the live inputs, since it is decided in IDLE
  always_comb begin
    w_legal = 1'b0;
    case (ls_ctrl)
      c_ls_word: w_legal = (addr_lo == 2'b00);
      c_ls_half: w_legal = ~addr_lo[0];
      c_ls_byte: w_legal = 1'b1;
      default:   w_legal = 1'b0;
    endcase
  end

  // Extraction uses only the latched request fields
  always_comb begin
    w_byte = mem_data[7:0];
    case (r_addr)
      2'd0:    w_byte = mem_data[7:0];
      2'd1:    w_byte = mem_data[15:8];
      2'd2:    w_byte = mem_data[23:16];
      default: w_byte = mem_data[31:24];
    endcase
    w_half = r_addr[1] ? mem_data[31:16] : mem_data[15:0];
    case (r_ls)
      c_ls_byte: w_ext = {{24{r_sign & w_byte[7]}}, w_byte};
      c_ls_half: w_ext = {{16{r_sign & w_half[15]}}, w_half};
      default:   w_ext = mem_data;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_ls_nxt     = r_ls;
    w_addr_nxt   = r_addr;
    w_sign_nxt   = r_sign;
    w_mem_rd_nxt = 1'b0;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_data_nxt   = r_data_out;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_legal) begin
            w_ls_nxt     = ls_ctrl;
            w_addr_nxt   = addr_lo;
            w_sign_nxt   = sign_en;
            w_mem_rd_nxt = 1'b1;
            w_state_nxt  = S_REQ;
          end else begin
            w_done_nxt  = 1'b1;
            w_err_nxt   = 1'b1;
            w_data_nxt  = 32'd0;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_REQ: begin
        w_cnt_nxt   = c_wait_init;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_data_nxt  = w_ext;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_ls       <= 2'd0;
      r_addr     <= 2'd0;
      r_sign     <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_data_out <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ls       <= w_ls_nxt;
      r_addr     <= w_addr_nxt;
      r_sign     <= w_sign_nxt;
      r_mem_rd   <= w_mem_rd_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_data_out <= w_data_nxt;
    end
  end

  assign mem_rd   = r_mem_rd;
  assign done     = r_done;
  assign err      = r_err;
  assign data_out = r_data_out;
  assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_load_size_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_size_unit
// Description : Directed bench driving a MEM_LAT=2 and a MEM_LAT=1 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_size_unit;

  logic        clk;
  logic        reset_n;
  logic [1:0]  start_v;
  logic [1:0]  ls_ctrl;
  logic [1:0]  addr_lo;
  logic        sign_en;
  logic [31:0] mem_word;
  logic [31:0] mdat0, mdat1, dout0, dout1;
  logic [1:0]  rd_v, done_v, err_v, busy_v;
  int          errors = 0;
  int          checks = 0;

  load_size_unit #(.MEM_LAT(2)) u_lat2 (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .ls_ctrl(ls_ctrl),
    .addr_lo(addr_lo), .sign_en(sign_en), .mem_data(mdat0), .mem_rd(rd_v[0]),
    .data_out(dout0), .done(done_v[0]), .err(err_v[0]), .busy(busy_v[0])
  );

  load_size_unit #(.MEM_LAT(1)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .ls_ctrl(ls_ctrl),
    .addr_lo(addr_lo), .sign_en(sign_en), .mem_data(mdat1), .mem_rd(rd_v[1]),
    .data_out(dout1), .done(done_v[1]), .err(err_v[1]), .busy(busy_v[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lat(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic [31:0] get_dout(input int i);
    return (i == 0) ? dout0 : dout1;
  endfunction

  // Memory model: read word is valid only in the cycle MEM_LAT after mem_rd
  initial begin
    int cnt [2];
    cnt[0] = 0;
    cnt[1] = 0;
    mdat0  = 32'hA5A5A5A5;
    mdat1  = 32'hA5A5A5A5;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rd_v[i]) cnt[i] = lat(i) + 1;
        else if (cnt[i] > 0) cnt[i] = cnt[i] - 1;
      end
      mdat0 = (cnt[0] == 1) ? mem_word : 32'hA5A5A5A5;
      mdat1 = (cnt[1] == 1) ? mem_word : 32'hA5A5A5A5;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [1:0] ls, input logic [1:0] ao, input logic sg,
                         input logic [31:0] word, input logic [31:0] exp_d,
                         input logic exp_e, input logic hold, input string tag);
    int          rd_cyc [2];
    int          dn_cyc [2];
    int          rd_n   [2];
    int          dn_n   [2];
    logic [31:0] got_d  [2];
    logic        got_e  [2];
    for (int i = 0; i < 2; i++) begin
      rd_cyc[i] = 0; dn_cyc[i] = 0; rd_n[i] = 0; dn_n[i] = 0;
      got_d[i] = 32'hxxxxxxxx; got_e[i] = 1'bx;
    end
    @(negedge clk);
    ls_ctrl = ls; addr_lo = ao; sign_en = sg; mem_word = word; start_v = 2'b11;
    @(posedge clk);
    #1;
    start_v = hold ? 2'b11 : 2'b00;
    ls_ctrl = ~ls; addr_lo = ~ao; sign_en = ~sg;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rd_v[i]) begin
          rd_n[i]++;
          if (rd_cyc[i] == 0) rd_cyc[i] = c;
        end
        if (done_v[i]) begin
          dn_n[i]++;
          if (dn_cyc[i] == 0) begin
            dn_cyc[i] = c;
            got_d[i]  = get_dout(i);
            got_e[i]  = err_v[i];
          end
        end
        start_v[i] = hold && (c + 1 <= 2 + lat(i));
      end
    end
    start_v = 2'b00;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_lat%0d_rd_count", tag, lat(i)), 32'(rd_n[i]), exp_e ? 32'd0 : 32'd1);
      chk($sformatf("%s_lat%0d_rd_cycle", tag, lat(i)), 32'(rd_cyc[i]), exp_e ? 32'd0 : 32'd1);
      chk($sformatf("%s_lat%0d_done_count", tag, lat(i)), 32'(dn_n[i]), 32'd1);
      chk($sformatf("%s_lat%0d_done_cycle", tag, lat(i)), 32'(dn_cyc[i]),
          exp_e ? 32'd1 : 32'(2 + lat(i)));
      chk($sformatf("%s_lat%0d_data", tag, lat(i)), got_d[i], exp_d);
      chk($sformatf("%s_lat%0d_err", tag, lat(i)), 32'(got_e[i]), 32'(exp_e));
      chk($sformatf("%s_lat%0d_data_held", tag, lat(i)), get_dout(i), exp_d);
      chk($sformatf("%s_lat%0d_idle_busy", tag, lat(i)), 32'(busy_v[i]), 32'd0);
    end
  endtask

  initial begin
    int n_done;
    int n_rd;
    reset_n  = 1'b0;
    start_v  = 2'b00;
    ls_ctrl  = 2'b00;
    addr_lo  = 2'b00;
    sign_en  = 1'b0;
    mem_word = 32'd0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_lat%0d_mem_rd", lat(i)), 32'(rd_v[i]), 32'd0);
      chk($sformatf("reset_lat%0d_done", lat(i)), 32'(done_v[i]), 32'd0);
      chk($sformatf("reset_lat%0d_err", lat(i)), 32'(err_v[i]), 32'd0);
      chk($sformatf("reset_lat%0d_busy", lat(i)), 32'(busy_v[i]), 32'd0);
      chk($sformatf("reset_lat%0d_data", lat(i)), get_dout(i), 32'd0);
    end
    reset_n = 1'b1;

    do_load(2'b00, 2'b00, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, "word");
    do_load(2'b10, 2'b11, 1'b1, 32'h80123456, 32'hFFFFFF80, 1'b0, 1'b0, "byte3_sx");
    do_load(2'b10, 2'b11, 1'b0, 32'h80123456, 32'h00000080, 1'b0, 1'b0, "byte3_zx");
    do_load(2'b10, 2'b01, 1'b1, 32'h0000F100, 32'hFFFFFFF1, 1'b0, 1'b0, "byte1_sx");
    do_load(2'b10, 2'b00, 1'b1, 32'hFFFFFF7F, 32'h0000007F, 1'b0, 1'b0, "byte0_pos");
    do_load(2'b01, 2'b10, 1'b0, 32'hBEEF1234, 32'h0000BEEF, 1'b0, 1'b0, "half2_zx");
    do_load(2'b01, 2'b10, 1'b1, 32'hBEEF1234, 32'hFFFFBEEF, 1'b0, 1'b0, "half2_sx");
    do_load(2'b01, 2'b00, 1'b1, 32'hBEEF1234, 32'h00001234, 1'b0, 1'b0, "half0_sx");
    do_load(2'b01, 2'b01, 1'b0, 32'h11111111, 32'h00000000, 1'b1, 1'b0, "err_half_mis");
    do_load(2'b11, 2'b00, 1'b0, 32'h22222222, 32'h00000000, 1'b1, 1'b0, "err_reserved");
    do_load(2'b00, 2'b10, 1'b0, 32'h33333333, 32'h00000000, 1'b1, 1'b0, "err_word_mis");
    do_load(2'b10, 2'b10, 1'b1, 32'h00A50000, 32'hFFFFFFA5, 1'b0, 1'b1, "busy_start");

    // Abort a load in WAIT: everything clears at once and no done follows
    @(negedge clk);
    ls_ctrl = 2'b00; addr_lo = 2'b00; sign_en = 1'b0;
    mem_word = 32'h2468ACE0; start_v = 2'b11;
    @(posedge clk);
    #1;
    start_v = 2'b00;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("abort_lat%0d_busy", lat(i)), 32'(busy_v[i]), 32'd0);
      chk($sformatf("abort_lat%0d_mem_rd", lat(i)), 32'(rd_v[i]), 32'd0);
      chk($sformatf("abort_lat%0d_done", lat(i)), 32'(done_v[i]), 32'd0);
      chk($sformatf("abort_lat%0d_data", lat(i)), get_dout(i), 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    n_done = 0;
    n_rd   = 0;
    repeat (6) begin
      @(negedge clk);
      n_done += int'(done_v[0]) + int'(done_v[1]);
      n_rd   += int'(rd_v[0]) + int'(rd_v[1]);
    end
    chk("abort_no_done", 32'(n_done), 32'd0);
    chk("abort_no_rd", 32'(n_rd), 32'd0);
    do_load(2'b00, 2'b00, 1'b1, 32'h13579BDF, 32'h13579BDF, 1'b0, 1'b0, "post_reset_word");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
